// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/D memory port arbiter: FSM state codes, owner
// codes and the RAM rd/wr control encodings used by the memory wrapper.
package mem_port_arbiter_pkg;

    // FSM state codes
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    // Transaction owner codes
    localparam logic [0:0] OWNER_IF = 1'b0;
    localparam logic [0:0] OWNER_D  = 1'b1;

    // RAM control field widths
    localparam int RD_CTRL_W = 3;
    localparam int WR_CTRL_W = 2;

    // RAM read control codes (load size/sign)
    localparam logic [RD_CTRL_W-1:0] RD_LB  = 3'b000;
    localparam logic [RD_CTRL_W-1:0] RD_LH  = 3'b001;
    localparam logic [RD_CTRL_W-1:0] RD_LW  = 3'b010;
    localparam logic [RD_CTRL_W-1:0] RD_LBU = 3'b100;
    localparam logic [RD_CTRL_W-1:0] RD_LHU = 3'b101;

    // RAM write control codes (store size)
    localparam logic [WR_CTRL_W-1:0] WR_NONE = 2'b00;
    localparam logic [WR_CTRL_W-1:0] WR_SB   = 2'b01;
    localparam logic [WR_CTRL_W-1:0] WR_SH   = 2'b11;
    localparam logic [WR_CTRL_W-1:0] WR_SW   = 2'b10;

    // Width of the timeout counter; one bit minimum so a disabled timeout
    // still yields a legal vector.
    function automatic int tmo_cnt_width(input int timeout);
        int w;
        w = (timeout > 0) ? $clog2(timeout + 1) : 1;
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-requester round-robin pick: a sole requester wins, a tie goes to B
// when prio_b is set and to A otherwise. Purely combinational.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic prio_b,
    output logic gnt_a,
    output logic gnt_b
);

    // Resolve the winner from the request pair and the tie-break priority
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            gnt_b = prio_b;
            gnt_a = ~prio_b;
        end else if (req_a) begin
            gnt_a = 1'b1;
        end else if (req_b) begin
            gnt_b = 1'b1;
        end else begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port (IF) and
// the load/store port (D). One transaction in flight, round-robin on ties,
// response routed back to the owner, optional response timeout with error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction fetch port
    input  logic                 if_req,
    input  logic [AW-1:0]        if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DW-1:0]        if_rdata,
    output logic                 if_err,
    // load/store port
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [AW-1:0]        d_addr,
    input  logic [DW-1:0]        d_wdata,
    input  logic [RD_CTRL_W-1:0] d_rd_ctrl,
    input  logic [WR_CTRL_W-1:0] d_wr_ctrl,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DW-1:0]        d_rdata,
    output logic                 d_err,
    // memory side
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic [RD_CTRL_W-1:0] mem_rd_ctrl,
    output logic [WR_CTRL_W-1:0] mem_wr_ctrl,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int            CW       = tmo_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
    localparam logic          TMO_EN   = (TIMEOUT > 0);

    logic [0:0]    state_q, state_d;
    logic [0:0]    owner_q, owner_d;
    logic          owner_we_q, owner_we_d;
    logic          prio_d_q, prio_d_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          pick_if_s;
    logic          pick_d_s;

    rr_pick2 u_pick (
        .req_a  (if_req),
        .req_b  (d_req),
        .prio_b (prio_d_q),
        .gnt_a  (pick_if_s),
        .gnt_b  (pick_d_s)
    );

    // Next-state and output decode; everything is forced quiet while rst is
    // held low so the outputs drop asynchronously with the reset.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_we_d = owner_we_q;
        prio_d_d   = prio_d_q;
        tmo_cnt_d  = tmo_cnt_q;

        if_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        if_err      = 1'b0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_rd_ctrl = '0;
        mem_wr_ctrl = '0;

        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_d_s) begin
                        mem_req     = 1'b1;
                        mem_we      = d_we;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        mem_rd_ctrl = d_rd_ctrl;
                        mem_wr_ctrl = d_wr_ctrl;
                    end else if (pick_if_s) begin
                        mem_req     = 1'b1;
                        mem_addr    = if_addr;
                        mem_rd_ctrl = RD_LW;
                    end else begin
                        mem_req     = 1'b0;
                    end

                    if (mem_req && mem_ready) begin
                        if_gnt     = pick_if_s;
                        d_gnt      = pick_d_s;
                        owner_d    = pick_d_s ? OWNER_D : OWNER_IF;
                        owner_we_d = pick_d_s & d_we;
                        prio_d_d   = pick_if_s;
                        tmo_cnt_d  = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (mem_rvalid) begin
                        // A response in the timeout cycle still wins.
                        if (owner_q == OWNER_D) begin
                            d_rvalid = 1'b1;
                            d_rdata  = owner_we_q ? '0 : mem_rdata;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end
                        state_d = ST_IDLE;
                    end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                        if (owner_q == OWNER_D) begin
                            d_rvalid = 1'b1;
                            d_err    = 1'b1;
                        end else begin
                            if_rvalid = 1'b1;
                            if_err    = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end

                    if (TMO_EN && (tmo_cnt_q != TMO_MAX)) begin
                        tmo_cnt_d = tmo_cnt_q + CW'(1);
                    end else begin
                        tmo_cnt_d = tmo_cnt_q;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_IF;
            owner_we_q <= 1'b0;
            prio_d_q   <= 1'b1;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
            prio_d_q   <= prio_d_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4: reset, tie
// alternation, sign-extended byte load, timeout error, store ack,
// backpressure, stray response, reset mid-WAIT and request withdrawal.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid, if_err;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_rd_ctrl;
    logic [1:0]    d_wr_ctrl;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_rd_ctrl;
    logic [1:0]    mem_wr_ctrl;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rd_ctrl(d_rd_ctrl), .d_wr_ctrl(d_wr_ctrl), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every output that must be quiet, packed into one vector
    function automatic logic [63:0] all_outs();
        return {mem_req, mem_we, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                (|if_rdata), (|d_rdata), (|mem_addr), (|mem_wdata),
                (|mem_rd_ctrl), (|mem_wr_ctrl)};
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0100;
        d_req      = 1'b1;
        d_we       = 1'b0;
        d_addr     = 32'h0000_0010;
        d_wdata    = 32'h0;
        d_rd_ctrl  = 3'b000;      // LB
        d_wr_ctrl  = 2'b00;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Reset holds every output low even with both ports requesting
        #3;
        check("reset_outs", all_outs(), 64'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;

        // Tie from reset: D first; it is the LB load at 0x10
        check("tie1_gnt", {if_gnt, d_gnt}, 64'h1);
        check("tie1_addr", mem_addr, 64'h10);
        check("tie1_rdctrl", {mem_we, mem_rd_ctrl}, 64'h0);

        // WAIT1, WAIT2: no request, no response
        tick();
        check("wait_quiet", {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid}, 64'h0);
        tick();
        // WAIT3: response 3 cycles after grant
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FF80;
        #1;
        check("load_rvalid", {if_rvalid, d_rvalid, d_err}, 64'h2);
        check("load_rdata", d_rdata, 64'hFFFF_FF80);
        check("load_if_rdata", if_rdata, 64'h0);

        // Second tie goes to IF with forced word read
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #1;
        check("tie2_gnt", {if_gnt, d_gnt}, 64'h2);
        check("tie2_fields", {mem_addr, 1'b0, mem_rd_ctrl}, {32'h100, 1'b0, 3'b010});

        // IF timeout: error in the 4th WAIT cycle, not the 3rd
        tick();
        tick();
        tick();
        check("tmo_early", {if_rvalid, if_err}, 64'h0);
        tick();
        check("tmo_err", {if_rvalid, if_err, d_rvalid}, 64'h6);
        check("tmo_rdata", if_rdata, 64'h0);

        // Back in IDLE: D wins the third tie, now a store
        d_we      = 1'b1;
        d_addr    = 32'h0000_0020;
        d_wdata   = 32'hCAFE_F00D;
        d_wr_ctrl = 2'b10;        // SW
        tick();
        check("tie3_gnt", {if_gnt, d_gnt}, 64'h1);
        check("store_fields", {mem_we, mem_wr_ctrl, mem_wdata}, {1'b1, 2'b10, 32'hCAFE_F00D});

        // Store ack one cycle after grant: rdata forced to 0
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        check("store_ack", {if_rvalid, d_rvalid, d_err}, 64'h2);
        check("store_rdata", d_rdata, 64'h0);

        // Backpressure on IF with a stray response in IDLE
        tick();
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_req", {mem_req, if_gnt, d_gnt, mem_addr}, {3'b100, 32'h100});
            check("stray_rvalid", {if_rvalid, d_rvalid}, 64'h0);
            tick();
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        #1;
        check("bp_release", {if_gnt, d_gnt}, 64'h2);

        // Reset while IF transaction is in WAIT
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("rst_wait_outs", all_outs(), 64'h0);
        tick();
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        #1;
        check("rst_release_gnt", {if_gnt, d_gnt, if_rvalid}, 64'h4);

        // D request withdrawn before grant: nothing issued
        tick();
        mem_rvalid = 1'b1;
        if_req     = 1'b0;
        #1;
        tick();
        mem_rvalid = 1'b0;
        d_req      = 1'b1;
        mem_ready  = 1'b0;
        #1;
        check("withdraw_req", {mem_req, d_gnt}, 64'h2);
        tick();
        d_req = 1'b0;
        #1;
        check("withdraw_idle", {mem_req, d_gnt, if_gnt}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
